// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the multi-cycle MIPS datapath: IF/ID/EX/MEM/WB with illegal-op and MEM timeout traps.
// Optional performance counters (CycleCnt, InstCnt) are built when MC_PERF_CNT_EN is defined.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [5:0]  OP,
  input  logic [5:0]  func,
  input  logic        Zero,
  input  logic        Overflow,
  input  logic        MemReady,
  output logic        PCWr,
  output logic [1:0]  PCSrc,
  output logic        IRWr,
  output logic        RegWr,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        MemRd,
  output logic        MemWr,
  output logic        ExtOp,
  output logic [2:0]  ALUctr,
  output logic        Err,
`ifdef MC_PERF_CNT_EN
  output logic [31:0] CycleCnt,
  output logic [31:0] InstCnt,
`endif
  output logic [2:0]  State
);

  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_AND, C_OR, C_SLT,
    C_ADDI, C_ORI, C_LW, C_SW, C_BEQ, C_J, C_ILL
  } cls_e;

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d, dec_cls;
  logic             ov_q, ov_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_rtype;

  // Instruction class decode; only consumed while in ID
  always_comb begin
    dec_cls = C_ILL;
    case (OP)
      6'b000000: begin
        case (func)
          6'b100000: dec_cls = C_ADD;
          6'b100010: dec_cls = C_SUB;
          6'b100100: dec_cls = C_AND;
          6'b100101: dec_cls = C_OR;
          6'b101010: dec_cls = C_SLT;
          default:   dec_cls = C_ILL;
        endcase
      end
      6'b001000: dec_cls = C_ADDI;
      6'b001101: dec_cls = C_ORI;
      6'b100011: dec_cls = C_LW;
      6'b101011: dec_cls = C_SW;
      6'b000100: dec_cls = C_BEQ;
      6'b000010: dec_cls = C_J;
      default:   dec_cls = C_ILL;
    endcase
  end

  assign is_rtype = (cls_q == C_ADD) || (cls_q == C_SUB) || (cls_q == C_AND) ||
                    (cls_q == C_OR)  || (cls_q == C_SLT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IF;
      cls_q   <= C_ADD;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and Moore outputs (PCWr follows Zero combinationally for beq)
  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    ov_d     = ov_q;
    cnt_d    = cnt_q;
    PCWr     = 1'b0;
    PCSrc    = PC_SEQ;
    IRWr     = 1'b0;
    RegWr    = 1'b0;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    ExtOp    = 1'b0;
    ALUctr   = ALU_ADD;
    case (state_q)
      S_IF: begin
        IRWr    = 1'b1;
        PCWr    = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        cls_d   = dec_cls;
        state_d = (dec_cls == C_ILL) ? S_ERR : S_EX;
      end
      S_EX: begin
        ov_d    = Overflow;
        cnt_d   = '0;
        state_d = S_WB;
        case (cls_q)
          C_SUB: ALUctr = ALU_SUB;
          C_AND: ALUctr = ALU_AND;
          C_OR:  ALUctr = ALU_OR;
          C_SLT: ALUctr = ALU_SLT;
          C_ADDI: begin
            ExtOp  = 1'b1;
            ALUSrc = 1'b1;
          end
          C_LW, C_SW: begin
            ExtOp   = 1'b1;
            ALUSrc  = 1'b1;
            state_d = S_MEM;
          end
          C_ORI: begin
            ALUSrc = 1'b1;
            ALUctr = ALU_OR;
          end
          C_BEQ: begin
            ALUctr  = ALU_SUB;
            PCSrc   = PC_BR;
            PCWr    = Zero;
            state_d = S_IF;
          end
          C_J: begin
            PCSrc   = PC_JMP;
            PCWr    = 1'b1;
            state_d = S_IF;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        MemRd = (cls_q == C_LW);
        MemWr = (cls_q == C_SW);
        if (MemReady) begin
          state_d = (cls_q == C_LW) ? S_WB : S_IF;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) state_d = S_ERR;
        end
      end
      S_WB: begin
        RegWr    = ~ov_q;
        RegDst   = is_rtype;
        MemtoReg = (cls_q == C_LW);
        state_d  = S_IF;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  assign Err   = (state_q == S_ERR);
  assign State = state_q;

`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_q, inst_q;
  logic        retire;

  assign retire = (state_d == S_IF) &&
                  ((state_q == S_EX) || (state_q == S_MEM) || (state_q == S_WB));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cyc_q  <= '0;
      inst_q <= '0;
    end else begin
      if (state_q != S_ERR) cyc_q <= cyc_q + 32'd1;
      if (retire)           inst_q <= inst_q + 32'd1;
    end
  end

  assign CycleCnt = cyc_q;
  assign InstCnt  = inst_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction vector table with a scoreboard queue,
// plus hand sequences for reset-in-MEM, illegal opcodes, MEM timeout and (MC_PERF_CNT_EN) perf counters.
module tb_multicycle_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [5:0]  OP, func;
  logic        Zero, Overflow, MemReady;
  logic        PCWr, IRWr, RegWr, RegDst, ALUSrc, MemtoReg, MemRd, MemWr, ExtOp, Err;
  logic [1:0]  PCSrc;
  logic [2:0]  ALUctr, State;
`ifdef MC_PERF_CNT_EN
  logic [31:0] CycleCnt, InstCnt;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  always #5 Clk = ~Clk;

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .Clk(Clk), .Reset(Reset), .OP(OP), .func(func), .Zero(Zero), .Overflow(Overflow),
    .MemReady(MemReady), .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr), .RegWr(RegWr),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .MemRd(MemRd), .MemWr(MemWr),
    .ExtOp(ExtOp), .ALUctr(ALUctr), .Err(Err),
`ifdef MC_PERF_CNT_EN
    .CycleCnt(CycleCnt), .InstCnt(InstCnt),
`endif
    .State(State)
  );

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    logic       ovf;
    logic [4:0] waits;
  } stim_t;

  typedef struct packed {
    logic [5:0] cycles;
    logic [3:0] if_bits;
    logic       id_any;
    logic [7:0] ex_grp;
    logic [3:0] wb_grp;
    logic [9:0] mem_grp;
    logic [2:0] end_state;
  } obs_t;

  typedef struct {
    stim_t s;
    obs_t  e;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                              input logic ovf, input int waits, input int cycles,
                              input logic pcwr, input logic [1:0] pcsrc, input logic [2:0] alu,
                              input logic alusrc, input logic extop, input logic wbseen,
                              input logic regwr, input logic regdst, input logic m2r,
                              input int rd, input int wr);
    vec_t v;
    v.s = '{op: op, fn: fn, zero: zero, ovf: ovf, waits: 5'(waits)};
    v.e.cycles    = 6'(cycles);
    v.e.if_bits   = 4'b1100;
    v.e.id_any    = 1'b0;
    v.e.ex_grp    = {pcwr, pcsrc, alu, alusrc, extop};
    v.e.wb_grp    = {wbseen, regwr, regdst, m2r};
    v.e.mem_grp   = {5'(rd), 5'(wr)};
    v.e.end_state = 3'd0;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Call right after a negedge with State == IF; returns at the negedge after the instruction ends
  task automatic run_instr(input stim_t s, output obs_t o, output logic [23:0] trace,
                           output bit done);
    int mem_seen = 0;
    o = '0;
    trace = '0;
    done = 0;
    OP = s.op; func = s.fn; Zero = s.zero; Overflow = s.ovf;
    for (int c = 0; c < 64; c++) begin
      MemReady = (State == 3'd3) && (mem_seen >= int'(s.waits));
      #1;
      if (o.cycles < 6'd8) trace[3*o.cycles +: 3] = State;
      o.cycles = o.cycles + 6'd1;
      case (State)
        3'd0: o.if_bits = {IRWr, PCWr, PCSrc};
        3'd1: o.id_any = PCWr | IRWr | RegWr | RegDst | ALUSrc | MemtoReg | MemRd | MemWr |
                         ExtOp | (|PCSrc) | (|ALUctr);
        3'd2: o.ex_grp = {PCWr, PCSrc, ALUctr, ALUSrc, ExtOp};
        3'd3: begin
          mem_seen++;
          if (MemRd) o.mem_grp[9:5] = o.mem_grp[9:5] + 5'd1;
          if (MemWr) o.mem_grp[4:0] = o.mem_grp[4:0] + 5'd1;
        end
        3'd4: o.wb_grp = {1'b1, RegWr, RegDst, MemtoReg};
        default: ;
      endcase
      @(negedge Clk);
      if (State == 3'd0 || State == 3'd7) begin
        done = 1;
        break;
      end
    end
    MemReady = 1'b0;
    o.end_state = State;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  vec_t        tbl[$];
  obs_t        sb[$];
  obs_t        got, exp_o;
  logic [23:0] trace;
  bit          done;

  initial begin
    Reset = 1'b1; OP = '0; func = '0; Zero = 0; Overflow = 0; MemReady = 0;
    //            op         fn         z  v  w   cyc pcwr pcsrc  alu   as ext wb rw rd m2r rd wr
    tbl.push_back(mk(6'h00, 6'b100000, 0, 0, 0,  4, 0, 2'b00, 3'b000, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(6'h00, 6'b100000, 0, 1, 0,  4, 0, 2'b00, 3'b000, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(6'h00, 6'b100010, 0, 0, 0,  4, 0, 2'b00, 3'b001, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(6'h00, 6'b100100, 0, 0, 0,  4, 0, 2'b00, 3'b010, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(6'h00, 6'b100101, 0, 0, 0,  4, 0, 2'b00, 3'b011, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(6'h00, 6'b101010, 0, 0, 0,  4, 0, 2'b00, 3'b100, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(6'h08, 6'h00,     0, 0, 0,  4, 0, 2'b00, 3'b000, 1, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(6'h08, 6'h00,     0, 1, 0,  4, 0, 2'b00, 3'b000, 1, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(6'h0d, 6'h00,     0, 0, 0,  4, 0, 2'b00, 3'b011, 1, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(6'h23, 6'h00,     0, 0, 3,  8, 0, 2'b00, 3'b000, 1, 1, 1, 1, 0, 1, 4, 0));
    tbl.push_back(mk(6'h23, 6'h00,     0, 0, 0,  5, 0, 2'b00, 3'b000, 1, 1, 1, 1, 0, 1, 1, 0));
    tbl.push_back(mk(6'h23, 6'h00,     0, 0, 14, 19, 0, 2'b00, 3'b000, 1, 1, 1, 1, 0, 1, 15, 0));
    tbl.push_back(mk(6'h2b, 6'h00,     0, 0, 0,  4, 0, 2'b00, 3'b000, 1, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(6'h2b, 6'h00,     0, 0, 2,  6, 0, 2'b00, 3'b000, 1, 1, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(6'h04, 6'h00,     1, 0, 0,  3, 1, 2'b01, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(6'h04, 6'h00,     0, 0, 0,  3, 0, 2'b01, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(6'h02, 6'h00,     0, 0, 0,  3, 1, 2'b10, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0));

    do_reset();
    #1;
    check("reset_state", 0, 32'(State), 32'd0);
    check("reset_err", 0, 32'(Err), 32'd0);
    check("reset_if_outputs", 0, 32'({IRWr, PCWr, PCSrc}), 32'b1100);
    @(negedge Clk);
    do_reset();

    foreach (tbl[i]) begin
      sb.push_back(tbl[i].e);
      run_instr(tbl[i].s, got, trace, done);
      exp_o = sb.pop_front();
      check("done", i, 32'(done), 32'd1);
      check("cycles", i, 32'(got.cycles), 32'(exp_o.cycles));
      check("if_out", i, 32'(got.if_bits), 32'(exp_o.if_bits));
      check("id_idle", i, 32'(got.id_any), 32'(exp_o.id_any));
      check("ex_out", i, 32'(got.ex_grp), 32'(exp_o.ex_grp));
      check("wb_out", i, 32'(got.wb_grp), 32'(exp_o.wb_grp));
      check("mem_cycles", i, 32'(got.mem_grp), 32'(exp_o.mem_grp));
      check("end_state", i, 32'(got.end_state), 32'(exp_o.end_state));
      if (i == 0) check("add_trace", i, 32'(trace), 32'({3'd4, 3'd2, 3'd1, 3'd0}));
    end

    // Reset while lw is stalled in MEM
    OP = 6'h23; func = '0; MemReady = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    check("pre_reset_mem", 0, 32'({State, MemRd}), 32'({3'd3, 1'b1}));
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("rst_in_mem", 0, 32'({State, MemRd, Err}), 32'({3'd0, 1'b0, 1'b0}));
    @(negedge Clk);
    do_reset();

    // Illegal opcode and unsupported R-type func both trap after ID
    for (int k = 0; k < 2; k++) begin
      OP = (k == 0) ? 6'h3f : 6'h00;
      func = (k == 0) ? 6'h00 : 6'b000001;
      repeat (2) @(negedge Clk);
      #1;
      check("ill_err", k, 32'({State, Err}), 32'({3'd7, 1'b1}));
      check("ill_quiet", k, 32'({PCWr, IRWr, RegWr, MemRd, MemWr, PCSrc}), 32'd0);
      OP = 6'h23;
      repeat (5) @(negedge Clk);
      #1;
      check("ill_sticky", k, 32'({State, Err}), 32'({3'd7, 1'b1}));
      @(negedge Clk);
      do_reset();
      #1;
      check("ill_cleared", k, 32'({State, Err}), 32'd0);
      @(negedge Clk);
      do_reset();
    end

    // lw with MemReady never asserted: 15 MEM cycles then ERR
    run_instr('{op: 6'h23, fn: 6'h00, zero: 1'b0, ovf: 1'b0, waits: 5'd31}, got, trace, done);
    check("to_state", 0, 32'(got.end_state), 32'd7);
    check("to_mem_cycles", 0, 32'(got.mem_grp), 32'({5'd15, 5'd0}));
    check("to_cycles", 0, 32'(got.cycles), 32'd18);
    #1;
    check("to_err", 0, 32'({Err, MemRd}), 32'b10);
    @(negedge Clk);
    do_reset();

`ifdef MC_PERF_CNT_EN
    do_reset();
    run_instr('{op: 6'h00, fn: 6'b100000, zero: 1'b0, ovf: 1'b0, waits: 5'd0}, got, trace, done);
    run_instr('{op: 6'h23, fn: 6'h00, zero: 1'b0, ovf: 1'b0, waits: 5'd0}, got, trace, done);
    run_instr('{op: 6'h04, fn: 6'h00, zero: 1'b1, ovf: 1'b0, waits: 5'd0}, got, trace, done);
    run_instr('{op: 6'h02, fn: 6'h00, zero: 1'b0, ovf: 1'b0, waits: 5'd0}, got, trace, done);
    #1;
    check("perf_inst", 0, InstCnt, 32'd4);
    check("perf_cycle", 0, CycleCnt, 32'd15);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
